// File: rtl/pulse_sync_scheduler.sv
// Shares one toggle pulse synchronizer among NREQ requesters, spacing pulses GAP cycles apart.
// Build option PSS_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module pss_lane (
  input  logic src_clk,
  input  logic src_rst_n,
  input  logic req,
  input  logic gnt,
  input  logic ovf_clr,
  output logic pend,
  output logic ovf,
  output logic pend_nxt
);
  logic ovf_nxt;

  // A granted event frees the slot in the same edge, so a coincident req is a new event.
  assign pend_nxt = (pend & ~gnt) | req;
  assign ovf_nxt  = (ovf & ~ovf_clr) | (req & pend & ~gnt);

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      pend <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      ovf  <= ovf_nxt;
    end
  end
endmodule

module pulse_sync_scheduler #(
  parameter int NREQ  = 4,
  parameter int CYCLE = 2,
  parameter int GAP   = 2*(CYCLE+1),
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic            src_clk,
  input  logic            src_rst_n,
  input  logic [NREQ-1:0] req,
  output logic            sync_pulse,
  output logic [IDW-1:0]  grant_id,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] ovf,
  input  logic [NREQ-1:0] ovf_clr,
  output logic            busy
);
  localparam int HCW = (GAP > 2) ? $clog2(GAP) : 1;

  if (GAP < 2 || NREQ < 2 || NREQ > 16 || CYCLE < 1) begin : g_bad_param
    $error("pulse_sync_scheduler: parameter out of range");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [HCW-1:0]  hold_cnt, hold_nxt;
  logic [IDW-1:0]  win;
  logic            found, grant;
  logic [NREQ-1:0] gnt, pend_nxt;

`ifdef PSS_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (pending[i]) begin
        win   = IDW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr, idx;

  // Search starts just after the last winner and wraps.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && pending[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (!src_rst_n)  ptr <= IDW'(NREQ-1);
    else if (grant)  ptr <= win;
  end
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gnt       = '0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant     = 1'b1;
          gnt[win]  = 1'b1;
          hold_nxt  = HCW'(GAP-2);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt = IDLE;
        else                hold_nxt  = hold_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    pss_lane u_lane (
      .src_clk  (src_clk),
      .src_rst_n(src_rst_n),
      .req      (req[i]),
      .gnt      (gnt[i]),
      .ovf_clr  (ovf_clr[i]),
      .pend     (pending[i]),
      .ovf      (ovf[i]),
      .pend_nxt (pend_nxt[i])
    );
  end

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      sync_pulse <= 1'b0;
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      sync_pulse <= grant;
      if (grant) grant_id <= win;
      busy       <= (state_nxt == HOLD) || (|pend_nxt);
    end
  end
endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Directed checks of capture, spacing, arbitration, overflow and reset, plus an
// end-to-end run through a toggle synchronizer into a slower clock.
`timescale 1ns/1ps
module tb_pulse_sync_scheduler;
  localparam int GAP  = 6;
  localparam int GAP2 = 18;

  logic       clk = 1'b0, dclk = 1'b0;
  logic       rst_n = 1'b0, rst2_n = 1'b0;
  logic [3:0] req = '0, clr = '0, req2 = '0, clr2 = '0;
  logic       sp, busy, sp2, busy2;
  logic [1:0] gid, gid2;
  logic [3:0] pend, ovf, pend2, ovf2;
  int         ntests = 0, nfail = 0;

  always #5    clk  = ~clk;
  always #13.5 dclk = ~dclk;

  pulse_sync_scheduler #(.NREQ(4), .CYCLE(2), .GAP(GAP)) u_dut (
    .src_clk(clk), .src_rst_n(rst_n), .req(req), .sync_pulse(sp), .grant_id(gid),
    .pending(pend), .ovf(ovf), .ovf_clr(clr), .busy(busy)
  );

  pulse_sync_scheduler #(.NREQ(4), .CYCLE(2), .GAP(GAP2)) u_e2e (
    .src_clk(clk), .src_rst_n(rst2_n), .req(req2), .sync_pulse(sp2), .grant_id(gid2),
    .pending(pend2), .ovf(ovf2), .ovf_clr(clr2), .busy(busy2)
  );

  // Toggle synchronizer: two stages plus an edge-detect flop in the slow domain.
  logic       tgl = 1'b0;
  logic [2:0] dsync = '0;
  int         src_cnt = 0, dst_cnt = 0;
  always @(posedge clk) if (sp2) begin tgl <= ~tgl; src_cnt <= src_cnt + 1; end
  always @(posedge dclk) begin
    dsync <= {dsync[1:0], tgl};
    if (dsync[2] ^ dsync[1]) dst_cnt <= dst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; clr = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp_p;
    tick(1);
    do_reset();
    chk("rst_pulse", 32'(sp), 0);
    chk("rst_gid",   32'(gid), 0);
    chk("rst_pend",  32'(pend), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_busy",  32'(busy), 0);

    // single event, cycle n
    req = 4'b0100; tick(); req = '0;
    chk("single_pend_n1", 32'(pend), 4'b0100);
    chk("single_nopulse_n1", 32'(sp), 0);
    chk("single_busy_n1", 32'(busy), 1);
    tick();
    chk("single_pulse_n2", 32'(sp), 1);
    chk("single_gid_n2", 32'(gid), 2);
    chk("single_pend_n2", 32'(pend), 0);
    tick();
    chk("single_pulse_n3", 32'(sp), 0);
    tick(3);
    chk("single_busy_n6", 32'(busy), 1);
    tick();
    chk("single_busy_n7", 32'(busy), 0);
    chk("single_gid_hold", 32'(gid), 2);

    // contention: all four at once
    do_reset();
    req = 4'hF; tick(); req = '0;
    for (int c = 1; c <= 24; c++) begin
      exp_p = (c >= 2) && (c <= 20) && ((c - 2) % GAP == 0);
      chk("cont_pulse", 32'(sp), 32'(exp_p));
      if (exp_p) chk("cont_gid", 32'(gid), 32'((c - 2) / GAP));
      tick();
    end

    // continuous req[0] with req[1]
    req = 4'b0011;
    tick(2);
    chk("cont0_pulse1", 32'(sp), 1);
    chk("cont0_gid1", 32'(gid), 0);
    tick(GAP);
    chk("cont0_pulse2", 32'(sp), 1);
`ifdef PSS_FIXED_PRIO_EN
    chk("cont0_gid2", 32'(gid), 0);
`else
    chk("cont0_gid2", 32'(gid), 1);
`endif
    tick(GAP);
    chk("cont0_gid3", 32'(gid), 0);
    req = '0;

    // overflow while another requester holds
    do_reset();
    req = 4'b0001; tick(); req = '0; tick();
    chk("ovf_hold_pulse", 32'(sp), 1);
    tick();
    req = 4'b0010; tick();
    chk("ovf_not_yet", 32'(ovf), 0);
    tick();
    req = '0;
    chk("ovf_set", 32'(ovf), 4'b0010);
    clr = 4'b0010; tick(); clr = '0;
    chk("ovf_cleared", 32'(ovf), 0);
    req = 4'b0010; clr = 4'b0010; tick(); req = '0; clr = '0;
    chk("ovf_set_wins", 32'(ovf), 4'b0010);
    tick();
    chk("ovf_after_pulse", 32'(sp), 1);
    chk("ovf_after_gid", 32'(gid), 1);

    // re-request in the grant cycle
    do_reset();
    req = 4'b1000; tick();
    tick();
    req = '0;
    chk("regrant_pulse", 32'(sp), 1);
    chk("regrant_pend", 32'(pend), 4'b1000);
    chk("regrant_ovf", 32'(ovf), 0);

    // re-request in the pulse cycle
    do_reset();
    req = 4'b1000; tick(); req = '0; tick();
    chk("repulse_pulse1", 32'(sp), 1);
    req = 4'b1000; tick(); req = '0;
    chk("repulse_pend", 32'(pend), 4'b1000);
    tick(4);
    chk("repulse_early", 32'(sp), 0);
    tick();
    chk("repulse_pulse2", 32'(sp), 1);
    chk("repulse_gid", 32'(gid), 3);
    chk("repulse_ovf", 32'(ovf), 0);

    // reset in the middle of HOLD
    do_reset();
    req = 4'b0100; tick(); req = '0; tick();
    chk("midrst_gid", 32'(gid), 2);
    req = 4'b1011; tick(); req = '0;
    chk("midrst_pend", 32'(pend), 4'b1011);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_pulse", 32'(sp), 0);
    chk("midrst_gid0", 32'(gid), 0);
    chk("midrst_pend0", 32'(pend), 0);
    chk("midrst_ovf0", 32'(ovf), 0);
    chk("midrst_busy0", 32'(busy), 0);
    req = 4'b0001; tick(); req = '0;
    chk("midrst_nopulse", 32'(sp), 0);
    tick();
    chk("midrst_newpulse", 32'(sp), 1);
    chk("midrst_newgid", 32'(gid), 0);

    // end to end through the slow domain
    rst2_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      req2 = 4'($urandom & $urandom & $urandom);
      tick();
    end
    req2 = '0;
    tick(150);
    chk("e2e_busy", 32'(busy2), 0);
    chk("e2e_active", 32'(src_cnt > 10), 1);
    chk("e2e_count", 32'(dst_cnt), 32'(src_cnt));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
